// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: widths, fetch FSM states and queue entry layout.
package legv8_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP = 32'hD503201F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two prefetch queue with synchronous flush; push into a full queue is
// accepted only when a pop frees the head in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only observed once counted valid.
    always_ff @(posedge clock) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 instruction fetch: single-outstanding request engine feeding a prefetch queue,
// with redirect handling that drains an in-flight response before refetching.
module instruction_fetch
    import legv8_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    fetch_state_t r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fetch_pc;
    fetch_entry_t      r_hold;

    fetch_state_t      w_state_next;
    logic              w_req_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_fetch_pc_next;
    logic [ADDR_W-1:0] w_target;
    logic [CW-1:0]     w_occ_next;
    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_ack;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_head;
    fetch_entry_t      w_wentry;

    // An ack only counts against a raised request, so stray acks are ignored.
    assign w_ack    = r_req && imem_ack;
    assign w_pop    = !w_empty && instr_ready;
    assign w_push   = w_ack && (r_state == ST_FETCH) && !redirect;
    assign w_target = word_align(redirect_pc);
    assign w_wentry = '{pc: r_addr, instr: imem_data};

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            ST_IDLE:  w_state_next = ST_FETCH;
            ST_FETCH: if (redirect && r_req && !imem_ack) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_ack) w_state_next = ST_FETCH;
            default:  w_state_next = ST_IDLE;
        endcase

        if (redirect) begin
            w_fetch_pc_next = w_target;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + 64'd4;
        end

        if (redirect) begin
            w_occ_next = '0;
        end else begin
            w_occ_next = w_count + CW'(w_push) - CW'(w_pop);
        end

        // A raised request is never withdrawn; otherwise issue against the post-edge occupancy.
        if (r_req && !imem_ack) begin
            w_req_next  = 1'b1;
            w_addr_next = r_addr;
        end else begin
            w_req_next  = (w_state_next == ST_FETCH) && (w_occ_next < DEPTH_C);
            w_addr_next = w_req_next ? w_fetch_pc_next : r_addr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_hold     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_addr     <= w_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (!w_empty) begin
                r_hold <= w_head;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? r_hold.instr : w_head.instr;
    assign instr_pc    = w_empty ? r_hold.pc    : w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, queue-full back-pressure, redirects and reset.
module tb_instruction_fetch;
    import legv8_pkg::*;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [63:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(
        .RESET_PC (64'h0),
        .QDEPTH   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mw(input logic [63:0] a);
        return 32'hA500_0000 ^ a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ack, input logic rdy, input logic redir, input logic [63:0] rpc);
        imem_ack    = ack;
        imem_data   = ack ? mw(imem_addr) : 32'hDEAD_BEEF;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        redirect = 1'b0;
    endtask

    logic [63:0] wrap_pc   [4];
    logic [63:0] wrap_addr [4];

    initial begin
        wrap_pc   = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
        wrap_addr = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8};
        reset = 1'b1; imem_ack = 1'b0; imem_data = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_req",   64'(imem_req), 64'd0);
        chk("rst_addr",  imem_addr, 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_pc",    instr_pc, 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // IDLE cycle with a stray ack: must be ignored
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("first_req",   64'(imem_req), 64'd1);
        chk("first_addr",  imem_addr, 64'h0);
        chk("late_ack_valid", 64'(instr_valid), 64'd0);
        chk("state_fetch", 64'(dut.r_state), 64'(ST_FETCH));

        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("lat_valid", 64'(instr_valid), 64'd1);
        chk("lat_pc",    instr_pc, 64'h0);
        chk("lat_instr", 64'(instr), 64'(mw(64'h0)));
        chk("lat_addr",  imem_addr, 64'h4);

        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0);
            chk("stream_valid", 64'(instr_valid), 64'd1);
            chk("stream_pc",    instr_pc, 64'(4 * k));
            chk("stream_instr", 64'(instr), 64'(mw(64'(4 * k))));
            chk("stream_addr",  imem_addr, 64'(4 * (k + 1)));
        end

        // Empty queue holds last head values
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("empty_valid", 64'(instr_valid), 64'd0);
        chk("empty_pc",    instr_pc, 64'h10);
        chk("empty_instr", 64'(instr), 64'(mw(64'h10)));
        chk("hold_addr",   imem_addr, 64'h14);
        chk("hold_req",    64'(imem_req), 64'd1);

        // Back-pressure: exactly two acks fill the queue
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("bp1_pc",   instr_pc, 64'h14);
        chk("bp1_req",  64'(imem_req), 64'd1);
        chk("bp1_addr", imem_addr, 64'h18);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("full_req", 64'(imem_req), 64'd0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        chk("full_req2", 64'(imem_req), 64'd0);
        chk("full_pc",   instr_pc, 64'h14);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("free_pc",   instr_pc, 64'h18);
        chk("free_req",  64'(imem_req), 64'd1);
        chk("free_addr", imem_addr, 64'h1C);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("refull_req", 64'(imem_req), 64'd0);

        // Redirect with a request outstanding -> DRAIN, stale ack dropped
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("dr_pre_pc",   instr_pc, 64'h1C);
        chk("dr_pre_addr", imem_addr, 64'h20);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("dr_pre_valid", 64'(instr_valid), 64'd0);
        step(1'b0, 1'b1, 1'b1, 64'h100);
        chk("drain_state", 64'(dut.r_state), 64'(ST_DRAIN));
        chk("drain_addr",  imem_addr, 64'h20);
        chk("drain_req",   64'(imem_req), 64'd1);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("drain_state2", 64'(dut.r_state), 64'(ST_DRAIN));
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("stale_valid", 64'(instr_valid), 64'd0);
        chk("post_drain_addr",  imem_addr, 64'h100);
        chk("post_drain_state", 64'(dut.r_state), 64'(ST_FETCH));
        step(1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("tgt_valid", 64'(instr_valid), 64'd1);
        chk("tgt_pc",    instr_pc, 64'h100);
        chk("tgt_instr", 64'(instr), 64'(mw(64'h100)));

        // Redirect coincident with ack and consume
        step(1'b1, 1'b1, 1'b1, 64'h203);
        chk("ra_valid", 64'(instr_valid), 64'd0);
        chk("ra_addr",  imem_addr, 64'h200);
        chk("ra_req",   64'(imem_req), 64'd1);
        chk("ra_state", 64'(dut.r_state), 64'(ST_FETCH));
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("ra_pc",    instr_pc, 64'h200);
        chk("ra_instr", 64'(instr), 64'(mw(64'h200)));

        // Address wrap
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_start", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 64'h0);
            chk("wrap_pc",   instr_pc, wrap_pc[k]);
            chk("wrap_addr", imem_addr, wrap_addr[k]);
        end

        // Redirect while draining takes the newest target
        step(1'b0, 1'b0, 1'b1, 64'h300);
        chk("dd_state", 64'(dut.r_state), 64'(ST_DRAIN));
        chk("dd_valid", 64'(instr_valid), 64'd0);
        step(1'b0, 1'b0, 1'b1, 64'h404);
        chk("dd_state2", 64'(dut.r_state), 64'(ST_DRAIN));
        chk("dd_addr",   imem_addr, 64'h8);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("dd_new_addr", imem_addr, 64'h404);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        chk("dd_pc",   instr_pc, 64'h404);
        chk("dd_req",  64'(imem_req), 64'd1);
        chk("dd_next", imem_addr, 64'h408);

        // Asynchronous reset mid-request
        #2 reset = 1'b0;
        #1;
        chk("ar_req",   64'(imem_req), 64'd0);
        chk("ar_addr",  imem_addr, 64'h0);
        chk("ar_valid", 64'(instr_valid), 64'd0);
        chk("ar_instr", 64'(instr), 64'h0);
        chk("ar_pc",    instr_pc, 64'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("ar2_req",   64'(imem_req), 64'd1);
        chk("ar2_addr",  imem_addr, 64'h0);
        chk("ar2_valid", 64'(instr_valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        chk("ar2_pc",    instr_pc, 64'h0);
        chk("ar2_vld",   64'(instr_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
